// File: rtl/fb_scanout.sv
// fb_scanout: scans a rectangular framebuffer window in row-major order and
// streams the pixels out over a valid/ready interface through a small
// output buffer. Reads are throttled so that buffered pixels plus the read
// in flight never exceed the buffer depth, so the buffer cannot overflow.
module fb_scanout #(
    parameter int FIFO_DEPTH = 4  // power of two, >= 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  win_x0,
    input  logic [7:0]  win_y0,
    input  logic [7:0]  win_x1,
    input  logic [7:0]  win_y1,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        fb_read_en,
    output logic [7:0]  fb_read_x,
    output logic [7:0]  fb_read_y,
    input  logic [23:0] fb_read_color,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [23:0] pix_data,
    output logic        pix_sof,
    output logic        pix_eol
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [23:0] color;
    } pix_t;

    state_t      state, state_nxt;

    // captured window and scan position
    logic [7:0]  x0_q, y0_q, x1_q, y1_q;
    logic [7:0]  cur_x, cur_y;
    logic        bad_q;

    // one read in flight: data arrives the cycle after the request
    logic        rf_vld, rf_sof, rf_eol;

    // output buffer
    pix_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   outstanding;
    pix_t        head;

    logic win_ok, start_ok, last_x, last_y, push, pop;

    assign win_ok      = (win_x1 >= win_x0) && (win_y1 >= win_y0);
    assign start_ok    = (state == IDLE) && start;
    assign last_x      = (cur_x == x1_q);
    assign last_y      = (cur_y == y1_q);
    assign outstanding = count + {{AW{1'b0}}, rf_vld};
    assign push        = rf_vld;
    assign pop         = pix_valid && pix_ready;
    assign head        = mem[rd_ptr];

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state and status/read outputs
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        fb_read_en = 1'b0;
        fb_read_x  = 8'd0;
        fb_read_y  = 8'd0;
        case (state)
            IDLE: begin
                if (start) state_nxt = win_ok ? SCAN : FIN;
            end
            SCAN: begin
                busy       = 1'b1;
                fb_read_en = (outstanding < (AW+1)'(FIFO_DEPTH));
                fb_read_x  = fb_read_en ? cur_x : 8'd0;
                fb_read_y  = fb_read_en ? cur_y : 8'd0;
                if (fb_read_en && last_x && last_y) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // leave as the buffer empties so done lands right after the
                // final transfer
                if (!rf_vld && ((count == '0) ||
                    ((count == (AW+1)'(1)) && pop)))
                    state_nxt = FIN;
            end
            FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                err       = bad_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // window capture and scan coordinate advance (compare before increment,
    // so an edge at 255 never wraps)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q  <= 8'd0;
            y0_q  <= 8'd0;
            x1_q  <= 8'd0;
            y1_q  <= 8'd0;
            cur_x <= 8'd0;
            cur_y <= 8'd0;
            bad_q <= 1'b0;
        end else if (start_ok) begin
            x0_q  <= win_x0;
            y0_q  <= win_y0;
            x1_q  <= win_x1;
            y1_q  <= win_y1;
            cur_x <= win_x0;
            cur_y <= win_y0;
            bad_q <= !win_ok;
        end else if (fb_read_en) begin
            if (last_x) begin
                cur_x <= x0_q;
                if (!last_y) cur_y <= cur_y + 8'd1;
            end else begin
                cur_x <= cur_x + 8'd1;
            end
        end
    end

    // in-flight read tag; cleared by reset so a pre-reset return is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_vld <= 1'b0;
            rf_sof <= 1'b0;
            rf_eol <= 1'b0;
        end else begin
            rf_vld <= fb_read_en;
            rf_sof <= fb_read_en && (cur_x == x0_q) && (cur_y == y0_q);
            rf_eol <= fb_read_en && last_x;
        end
    end

    // buffer pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // buffer storage, written with the returning color and its flags
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{sof: rf_sof, eol: rf_eol, color: fb_read_color};
    end

    // pixel stream: head entry is gated so outputs read zero when empty
    always_comb begin
        pix_valid = (count != '0);
        pix_data  = pix_valid ? head.color : 24'd0;
        pix_sof   = pix_valid && head.sof;
        pix_eol   = pix_valid && head.eol;
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: a framebuffer responder with a seeded color pattern,
// and a window-level model that lists the expected reads and pixels.
module tb_fb_scanout;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  win_x0 = '0, win_y0 = '0, win_x1 = '0, win_y1 = '0;
    logic        busy, done, err, fb_read_en;
    logic [7:0]  fb_read_x, fb_read_y;
    logic [23:0] fb_read_color = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [23:0] pix_data;
    logic        pix_sof, pix_eol;

    int checks = 0;
    int errors = 0;
    logic [15:0] seed = 16'h1234;

    fb_scanout #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .win_x0(win_x0), .win_y0(win_y0), .win_x1(win_x1), .win_y1(win_y1),
        .busy(busy), .done(done), .err(err),
        .fb_read_en(fb_read_en), .fb_read_x(fb_read_x), .fb_read_y(fb_read_y),
        .fb_read_color(fb_read_color),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eol(pix_eol)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] fcolor(input logic [7:0] x, input logic [7:0] y);
        return {x ^ seed[7:0], y + seed[15:8], x + y};
    endfunction

    // framebuffer: data valid the cycle after a read, garbage otherwise
    always @(posedge clk)
        fb_read_color <= fb_read_en ? fcolor(fb_read_x, fb_read_y) : 24'($urandom);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_flags"}, {busy, done, err, fb_read_en, pix_valid, pix_sof, pix_eol}, 0);
        check({tag, "_data"}, {fb_read_x, fb_read_y, pix_data}, 0);
    endtask

    // mode 0: ready held 1; 1: random ready; 2: ready low for 6 cycles after first read
    task automatic run_window(input logic [7:0] x0, input logic [7:0] y0,
                              input logic [7:0] x1, input logic [7:0] y1,
                              input int mode, input bit poke);
        logic [25:0] expq[$];
        logic [15:0] rdq[$];
        logic [26:0] held;
        int n, first_read, last_read, first_valid, last_xfer, budget;
        bit hold, fin;
        seed = 16'($urandom);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                rdq.push_back({8'(x), 8'(y)});
                expq.push_back({(x == x0 && y == y0), (x == x1), fcolor(8'(x), 8'(y))});
            end
        n = expq.size();
        budget = n * 8 + 40;
        first_read = -1; last_read = -1; first_valid = -1; last_xfer = -1;
        hold = 0; fin = 0; held = '0;
        @(negedge clk);
        check("idle_before", busy, 0);
        start = 1; win_x0 = x0; win_y0 = y0; win_x1 = x1; win_y1 = y1;
        pix_ready = (mode == 0);
        @(negedge clk);
        start = 0;
        check("busy_rise", busy, 1);
        for (int k = 0; k < budget && !fin; k++) begin
            start = 0;
            if (fb_read_en) begin
                if (first_read < 0) first_read = k;
                last_read = k;
                if (rdq.size() == 0) check("extra_read", {fb_read_x, fb_read_y}, 32'hffff_ffff);
                else check("read_xy", {fb_read_x, fb_read_y}, rdq.pop_front());
            end else begin
                check("read_xy_idle", {fb_read_x, fb_read_y}, 0);
            end
            if (pix_valid && first_valid < 0) first_valid = k;
            if (hold) check("stable", {pix_valid, pix_sof, pix_eol, pix_data}, held);
            case (mode)
                0: pix_ready = 1;
                1: pix_ready = 1'($urandom_range(0, 1));
                default: pix_ready = !(first_read < 0 || k <= first_read + 6);
            endcase
            if (pix_valid && pix_ready) begin
                if (expq.size() == 0) check("extra_pixel", {pix_sof, pix_eol, pix_data}, 32'hffff_ffff);
                else check("pixel", {pix_sof, pix_eol, pix_data}, expq.pop_front());
                last_xfer = k;
            end
            hold = pix_valid && !pix_ready;
            held = {pix_valid, pix_sof, pix_eol, pix_data};
            if (done) begin
                check("err_on_done", err, 0);
                check("done_timing", k, last_xfer + 1);
                check("pixels_left", expq.size(), 0);
                check("reads_left", rdq.size(), 0);
                fin = 1;
                // start in the FIN cycle must be ignored
                start = 1; win_x0 = 0; win_y0 = 0; win_x1 = 0; win_y1 = 0;
            end else if (poke && k == 2) begin
                // start while busy must be ignored
                start = 1; win_x0 = 0; win_y0 = 0; win_x1 = 9; win_y1 = 9;
            end
            @(negedge clk);
        end
        start = 0;
        if (!fin) check("timeout", 0, 1);
        check("busy_fall", {busy, done}, 0);
        if (mode == 0) begin
            check("first_pix_latency", first_valid, first_read + 2);
            check("read_rate", last_read - first_read, n - 1);
        end
    endtask

    task automatic run_bad(input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] x1, input logic [7:0] y1);
        @(negedge clk);
        start = 1; win_x0 = x0; win_y0 = y0; win_x1 = x1; win_y1 = y1;
        @(negedge clk);
        start = 0;
        check("bad_fin", {busy, done, err, fb_read_en}, 4'b1110);
        @(negedge clk);
        check_quiet("bad_after");
    endtask

    initial begin
        logic [7:0] rx0, ry0, rx1, ry1;
        int w, h;
        #1;
        check_quiet("reset_initial");
        #20;
        @(negedge clk);
        rst_n = 1;

        run_window(8'd10, 8'd20, 8'd11, 8'd21, 0, 0);
        run_window(8'd10, 8'd20, 8'd11, 8'd21, 2, 0);
        run_window(8'd0, 8'd7, 8'd255, 8'd7, 0, 0);
        run_bad(8'd5, 8'd0, 8'd4, 8'd0);
        run_bad(8'd0, 8'd9, 8'd3, 8'd8);

        // reset mid-scan with a read in flight, released before its data returns
        @(negedge clk);
        start = 1; win_x0 = 0; win_y0 = 0; win_x1 = 3; win_y1 = 3;
        pix_ready = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        check("scan_before_reset", {busy, fb_read_en}, 2'b11);
        #1 rst_n = 0;
        #1 check_quiet("reset_async");
        #1 rst_n = 1;
        run_window(8'd0, 8'd0, 8'd0, 8'd0, 0, 1);

        run_window(8'd250, 8'd253, 8'd255, 8'd255, 1, 1);
        for (int i = 0; i < 8; i++) begin
            rx0 = 8'($urandom_range(0, 255));
            ry0 = 8'($urandom_range(0, 255));
            w = $urandom_range(1, 12);
            h = $urandom_range(1, 3);
            rx1 = (rx0 + w - 1 > 255) ? 8'd255 : 8'(rx0 + w - 1);
            ry1 = (ry0 + h - 1 > 255) ? 8'd255 : 8'(ry0 + h - 1);
            run_window(rx0, ry0, rx1, ry1, (i % 3 == 2) ? 0 : 1, i[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: output buffer entries; power of two, minimum 4.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  one-cycle request to scan the window; ignored while busy=1.
REQ-005 win_x0, win_y0, win_x1, win_y1  input  8 each  inclusive window corners, sampled on accepted start.
REQ-006 busy  output  1  scan in progress.
REQ-007 done  output  1  one-cycle pulse at scan end.
REQ-008 err  output  1  one-cycle pulse on invalid window.
REQ-009 fb_read_en  output  1  framebuffer read request.
REQ-010 fb_read_x, fb_read_y  output  8 each  read coordinates, valid with fb_read_en.
REQ-011 fb_read_color  input  24  read data, valid in the cycle after fb_read_en.
REQ-012 pix_valid  output  1  pixel stream valid.
REQ-013 pix_ready  input  1  pixel stream ready.
REQ-014 pix_data  output  24  pixel color.
REQ-015 pix_sof  output  1  marks first pixel of the window.
REQ-016 pix_eol  output  1  marks last pixel of each row.

Function
REQ-017 FSM states: IDLE, SCAN, DRAIN, FIN; IDLE->SCAN on start with valid window; SCAN->DRAIN after last read issued; DRAIN->FIN when buffer empty and no read in flight; FIN->IDLE unconditionally.
REQ-018 Start in IDLE with win_x1<win_x0 or win_y1<win_y0: enter FIN, pulse err together with done, issue no reads.
REQ-019 busy = 1 in SCAN, DRAIN, FIN... deasserted in IDLE; busy rises in the cycle after accepted start.
REQ-020 Scan order row-major: x from win_x0 to win_x1 inner, y from win_y0 to win_y1 outer; exactly (x1-x0+1)*(y1-y0+1) reads and pixels.
REQ-021 Coordinate advance by equality compare against x1/y1 before increment; x1=255 or y1=255 shall not wrap or cause extra reads.
REQ-022 Read issued in cycle t: fb_read_color sampled at end of cycle t+1 and written to the buffer with its sof/eol flags (26 bits per entry).
REQ-023 Outstanding count = buffer occupancy + reads in flight; fb_read_en asserted in SCAN only when outstanding < FIFO_DEPTH.
REQ-024 With pix_ready held 1, sustained rate shall be one read and one pixel per cycle; first pix_valid in cycle t+2 after first read.
REQ-025 pix_valid = buffer non-empty; pix_data/sof/eol shall stay stable while pix_valid=1 and pix_ready=0; transfer on pix_valid & pix_ready.
REQ-026 Buffer shall never overflow or drop data; simultaneous push and pop in one cycle leaves occupancy unchanged.
REQ-027 done pulses in FIN, i.e. the cycle after the last pixel transfer; start arriving in the FIN cycle is ignored.
REQ-028 pix_sof = 1 only on the (x0,y0) pixel; pix_eol = 1 on every x=x1 pixel; 1x1 window has both set.
REQ-029 fb_read_x/fb_read_y = 0 whenever fb_read_en = 0.

Reset
REQ-030 rst_n low: FSM to IDLE, buffer flushed, in-flight reads discarded, busy/done/err/fb_read_en/pix_valid/pix_sof/pix_eol = 0, all data outputs = 0, immediately (asynchronously).
REQ-031 Read data returning after reset deassertion from a pre-reset read shall be discarded.
REQ-032 First start after rst_n rises shall be accepted normally.

Verification
REQ-033 Reset: rst_n low mid-cycle -> all outputs 0 before next clk edge.
REQ-034 Window (10,20)-(11,21), pix_ready=1 -> reads (10,20),(11,20),(10,21),(11,21) on consecutive cycles; 4 pixels, sof on 1st, eol on 2nd and 4th, done one cycle after 4th transfer.
REQ-035 Same window, pix_ready=0 for 6 cycles after first read -> exactly 4 reads then fb_read_en=0, pix_data stable, all 4 pixels delivered in order after release.
REQ-036 Window (0,7)-(255,7) -> 256 pixels, x 0..255, single eol at x=255, no 257th read.
REQ-037 Window x0=5,x1=4 -> err and done pulse same cycle, fb_read_en never asserted, busy returns 0.
REQ-038 rst_n asserted during SCAN of (0,0)-(3,3), released, start (0,0)-(0,0) -> exactly one pixel with sof=eol=1, no stale data; start during busy -> ignored.
